// File: rtl/usb2_ulpi_link_if.sv
// ULPI PHY bus bundle: link-to-PHY stop/data/output-enable and PHY-to-link
// direction/throttle/data. The link uses "master", a PHY model uses "slave".
interface usb2_ulpi_link_if;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic       ulpi_stp;
    logic [7:0] ulpi_data_in;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe;

    modport master (
        input  ulpi_dir,
        input  ulpi_nxt,
        input  ulpi_data_in,
        output ulpi_stp,
        output ulpi_data_out,
        output ulpi_data_oe
    );

    modport slave (
        output ulpi_dir,
        output ulpi_nxt,
        output ulpi_data_in,
        input  ulpi_stp,
        input  ulpi_data_out,
        input  ulpi_data_oe
    );
endinterface

// File: rtl/usb2_ulpi_link.sv
// ULPI link-layer front end for a USB 2.0 packet handler.
// Turns the 8-bit SDR ULPI bus into the in_act/in_byte/in_latch receive
// stream, executes transmit requests and PHY register writes, and decodes
// RX CMD bytes into line-state/status outputs.
// Optional feature macro: ULPI_REG_READ_EN adds PHY register reads
// (ports reg_rd_req, reg_rdata). Without it no read logic is built.
module usb2_ulpi_link #(
    parameter int POR_STP_CYCLES = 16,
    parameter int REG_WR_TIMEOUT = 255
) (
    input  logic       phy_clk,
    input  logic       reset_n,
    usb2_ulpi_link_if.master ulpi,
    output logic       in_act,
    output logic [7:0] in_byte,
    output logic       in_latch,
    output logic       out_cts,
    output logic       out_nxt,
    input  logic [7:0] out_byte,
    input  logic       out_latch,
    input  logic       out_stp,
    output logic [1:0] line_state,
    output logic [1:0] vbus_state,
    output logic       rx_error,
    output logic       host_disc,
    output logic       tx_abort,
    input  logic       reg_wr_req,
    input  logic [5:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic       reg_done,
    output logic       reg_err
`ifdef ULPI_REG_READ_EN
    ,
    input  logic       reg_rd_req,
    output logic [7:0] reg_rdata
`endif
);

    typedef enum logic [3:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_TX_CMD,
        ST_TX_DATA,
        ST_REG_CMD,
        ST_REG_DATA,
        ST_REG_STP
`ifdef ULPI_REG_READ_EN
        ,
        ST_RD_CMD,
        ST_RD_TURN,
        ST_RD_DATA,
        ST_RD_WAIT
`endif
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        dir_q;
    logic        turnaround;
    logic        rx_valid;
    logic        rx_block;
    logic        reg_busy;
    logic [15:0] dc;
    logic [15:0] wcnt;
    logic        timeout;
    logic        tx_abort_set;
    logic        reg_ok;
    logic        reg_fail;
    logic        stp_c;
    logic        oe_c;
    logic [7:0]  dout_c;

    // Any cycle where dir differs from the previous cycle is a bus turnaround.
    assign turnaround = ulpi.ulpi_dir ^ dir_q;
    assign timeout    = (wcnt >= 16'(REG_WR_TIMEOUT - 1));

`ifdef ULPI_REG_READ_EN
    // The register-read data byte arrives with dir=1/nxt=0 and must not be
    // mistaken for an RX CMD.
    assign rx_block = (state == ST_RD_DATA);
    assign reg_busy = reg_wr_req | reg_rd_req |
                      (state inside {ST_REG_CMD, ST_REG_DATA, ST_REG_STP,
                                     ST_RD_CMD, ST_RD_TURN, ST_RD_DATA, ST_RD_WAIT});
`else
    assign rx_block = 1'b0;
    assign reg_busy = reg_wr_req | (state inside {ST_REG_CMD, ST_REG_DATA, ST_REG_STP});
`endif

    assign rx_valid = ulpi.ulpi_dir & ~turnaround & ~rx_block;

    // State register.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_STARTUP;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
            state <= state_nxt;
        end
    end

    // Previous dir, startup stp counter and per-phase wait counter.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q <= 1'b0;
            dc    <= '0;
            wcnt  <= '0;
        end else begin
            dir_q <= ulpi.ulpi_dir;
            if (state == ST_STARTUP && dc != '1)
                dc <= dc + 16'd1;
            if (state_nxt != state)
                wcnt <= '0;
            else if (wcnt != '1)
                wcnt <= wcnt + 16'd1;
        end
    end

    // Next-state logic plus the one-cycle completion/abort events.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nxt    = state;
        tx_abort_set = 1'b0;
        reg_ok       = 1'b0;
        reg_fail     = 1'b0;
        case (state)
            ST_STARTUP: begin
                if (dc >= 16'(POR_STP_CYCLES - 1) && !ulpi.ulpi_dir)
                    state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                // Transmit wins over register access; reg_done blocks the
                // still-held request in the cycle the access completes.
                if (!ulpi.ulpi_dir) begin
                    if (out_latch)
                        state_nxt = ST_TX_CMD;
                    else if (reg_wr_req && !reg_done)
                        state_nxt = ST_REG_CMD;
`ifdef ULPI_REG_READ_EN
                    else if (reg_rd_req && !reg_done)
                        state_nxt = ST_RD_CMD;
`endif
                end
            end
            ST_TX_CMD, ST_TX_DATA: begin
                if (ulpi.ulpi_dir) begin
                    tx_abort_set = 1'b1;
                    state_nxt    = ST_IDLE;
                end else if (state == ST_TX_CMD && ulpi.ulpi_nxt) begin
                    state_nxt = ST_TX_DATA;
                end else if (state == ST_TX_DATA && out_stp) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REG_CMD, ST_REG_DATA: begin
                // The PHY taking the bus or a stalled handshake abandons the write.
                if (ulpi.ulpi_dir) begin
                    reg_fail  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (ulpi.ulpi_nxt) begin
                    state_nxt = (state == ST_REG_CMD) ? ST_REG_DATA : ST_REG_STP;
                end else if (timeout) begin
                    reg_fail  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_REG_STP: begin
                reg_ok    = 1'b1;
                state_nxt = ST_IDLE;
            end
`ifdef ULPI_REG_READ_EN
            ST_RD_CMD: begin
                if (ulpi.ulpi_dir) begin
                    reg_fail  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (ulpi.ulpi_nxt) begin
                    state_nxt = ST_RD_TURN;
                end else if (timeout) begin
                    reg_fail  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD_TURN: begin
                // dir rising with nxt is an RX start, which pre-empts the read.
                if (ulpi.ulpi_dir) begin
                    if (ulpi.ulpi_nxt) begin
                        reg_fail  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_RD_DATA;
                    end
                end else if (timeout) begin
                    reg_fail  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD_DATA: begin
                if (ulpi.ulpi_dir) begin
                    state_nxt = ST_RD_WAIT;
                end else begin
                    reg_fail  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (!ulpi.ulpi_dir) begin
                    reg_ok    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timeout) begin
                    reg_fail  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_STARTUP;
        endcase
    end

    // Bus drive: stp, output enable, outgoing byte and the transmit throttle.
    always_comb begin
        stp_c   = 1'b0;
        oe_c    = 1'b0;
        dout_c  = 8'h00;
        out_nxt = 1'b0;
        case (state)
            ST_STARTUP: stp_c = 1'b1;
            ST_TX_CMD: begin
                // The handler also needs nxt here to advance past the TX CMD byte.
                oe_c    = 1'b1;
                dout_c  = out_byte;
                out_nxt = ulpi.ulpi_nxt;
            end
            ST_TX_DATA: begin
                oe_c = 1'b1;
                if (out_stp) begin
                    stp_c = ~ulpi.ulpi_dir;
                end else begin
                    dout_c  = out_byte;
                    out_nxt = ulpi.ulpi_nxt;
                end
            end
            ST_REG_CMD: begin
                oe_c   = 1'b1;
                dout_c = 8'h80 | {2'b00, reg_addr};
            end
            ST_REG_DATA: begin
                oe_c   = 1'b1;
                dout_c = reg_wdata;
            end
            ST_REG_STP: begin
                oe_c  = 1'b1;
                stp_c = 1'b1;
            end
`ifdef ULPI_REG_READ_EN
            ST_RD_CMD: begin
                oe_c   = 1'b1;
                dout_c = 8'hC0 | {2'b00, reg_addr};
            end
`endif
            default: ;
        endcase
        // Never fight the PHY: release the bus whenever it owns or is turning it.
        if (ulpi.ulpi_dir || turnaround) begin
            oe_c    = 1'b0;
            out_nxt = 1'b0;
        end
    end

    assign ulpi.ulpi_stp      = stp_c;
    assign ulpi.ulpi_data_oe  = oe_c;
    assign ulpi.ulpi_data_out = dout_c;

    // Receive path: RX CMD decode, data byte capture and in_act tracking.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            in_act     <= 1'b0;
            in_byte    <= 8'h00;
            in_latch   <= 1'b0;
            line_state <= 2'b00;
            vbus_state <= 2'b00;
            rx_error   <= 1'b0;
            host_disc  <= 1'b0;
        end else begin
            in_latch <= 1'b0;
            rx_error <= 1'b0;
            if (rx_valid) begin
                if (!ulpi.ulpi_nxt) begin
                    line_state <= ulpi.ulpi_data_in[1:0];
                    vbus_state <= ulpi.ulpi_data_in[3:2];
                    in_act     <= ulpi.ulpi_data_in[4];
                    rx_error   <= (ulpi.ulpi_data_in[5:4] == 2'b11);
                    host_disc  <= (ulpi.ulpi_data_in[5:4] == 2'b10);
                end else begin
                    in_byte  <= ulpi.ulpi_data_in;
                    in_latch <= 1'b1;
                end
            end else if (turnaround) begin
                if (ulpi.ulpi_dir && ulpi.ulpi_nxt)
                    in_act <= 1'b1;
                else if (!ulpi.ulpi_dir)
                    in_act <= 1'b0;
            end
        end
    end

    // Registered handler status: clear-to-send, abort and register completion.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_cts  <= 1'b0;
            tx_abort <= 1'b0;
            reg_done <= 1'b0;
            reg_err  <= 1'b0;
        end else begin
            out_cts  <= (state == ST_IDLE) & ~ulpi.ulpi_dir & ~in_act & ~reg_busy;
            tx_abort <= tx_abort_set;
            reg_done <= reg_ok | reg_fail;
            reg_err  <= reg_fail;
        end
    end

`ifdef ULPI_REG_READ_EN
    // Read data capture in the cycle after the read turnaround.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n)
            reg_rdata <= 8'h00;
        else if (state == ST_RD_DATA && ulpi.ulpi_dir)
            reg_rdata <= ulpi.ulpi_data_in;
    end
`endif

endmodule

// File: tb/tb_usb2_ulpi_link.sv
// Directed testbench for usb2_ulpi_link: startup, receive, RX CMD decode,
// transmit, register write (ok and timeout), transmit abort, async reset.
module tb_usb2_ulpi_link;
    logic       phy_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_act, in_latch, out_cts, out_nxt;
    logic [7:0] in_byte;
    logic [7:0] out_byte = 8'h00;
    logic       out_latch = 1'b0;
    logic       out_stp = 1'b0;
    logic [1:0] line_state, vbus_state;
    logic       rx_error, host_disc, tx_abort;
    logic       reg_wr_req = 1'b0;
    logic [5:0] reg_addr = 6'h04;
    logic [7:0] reg_wdata = 8'h45;
    logic       reg_done, reg_err;
`ifdef ULPI_REG_READ_EN
    logic       reg_rd_req = 1'b0;
    logic [7:0] reg_rdata;
`endif

    int checks = 0;
    int failures = 0;

    usb2_ulpi_link_if bus();

    usb2_ulpi_link dut (
        .phy_clk    (phy_clk),
        .reset_n    (reset_n),
        .ulpi       (bus),
        .in_act     (in_act),
        .in_byte    (in_byte),
        .in_latch   (in_latch),
        .out_cts    (out_cts),
        .out_nxt    (out_nxt),
        .out_byte   (out_byte),
        .out_latch  (out_latch),
        .out_stp    (out_stp),
        .line_state (line_state),
        .vbus_state (vbus_state),
        .rx_error   (rx_error),
        .host_disc  (host_disc),
        .tx_abort   (tx_abort),
        .reg_wr_req (reg_wr_req),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_done   (reg_done),
        .reg_err    (reg_err)
`ifdef ULPI_REG_READ_EN
        ,
        .reg_rd_req (reg_rd_req),
        .reg_rdata  (reg_rdata)
`endif
    );

    always #5 phy_clk = ~phy_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive all inputs just after the falling edge, then settle.
    task automatic tick(input logic d, input logic n, input logic [7:0] din,
                        input logic lat, input logic [7:0] ob, input logic ostp,
                        input logic wreq);
        @(negedge phy_clk);
        bus.ulpi_dir     = d;
        bus.ulpi_nxt     = n;
        bus.ulpi_data_in = din;
        out_latch        = lat;
        out_byte         = ob;
        out_stp          = ostp;
        reg_wr_req       = wreq;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 0, 8'h00, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "testbench watchdog");
    end

    initial begin
        logic [7:0] rx_bytes [5];
        int stp_cnt;
        int wait_n;
        rx_bytes[0] = 8'hC3; rx_bytes[1] = 8'h01; rx_bytes[2] = 8'h02;
        rx_bytes[3] = 8'h5E; rx_bytes[4] = 8'hA7;

        bus.ulpi_dir = 1'b0;
        bus.ulpi_nxt = 1'b0;
        bus.ulpi_data_in = 8'h00;

        // Reset values.
        repeat (3) @(posedge phy_clk);
        #1;
        check("rst_stp", bus.ulpi_stp, 1);
        check("rst_oe", bus.ulpi_data_oe, 0);
        check("rst_dout", bus.ulpi_data_out, 0);
        check("rst_in_act", in_act, 0);
        check("rst_in_latch", in_latch, 0);
        check("rst_in_byte", in_byte, 0);
        check("rst_cts", out_cts, 0);
        check("rst_rx_error", rx_error, 0);
        check("rst_tx_abort", tx_abort, 0);
        check("rst_reg_done", reg_done, 0);
        check("rst_reg_err", reg_err, 0);
        check("rst_line", {line_state, vbus_state, host_disc}, 0);

        // Startup: stp high for 16 cycles, cts one cycle after idle.
        @(posedge phy_clk);
        #2 reset_n = 1'b1;
        stp_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge phy_clk);
            #1;
            if (bus.ulpi_stp) stp_cnt++;
            else break;
        end
        check("por_stp_cycles", stp_cnt, 16);
        check("por_cts_first_idle", out_cts, 0);
        idle(1);
        check("por_cts_after", out_cts, 1);

        // Receive packet: dir rises with nxt, five bytes, dir falls.
        tick(1, 1, 8'h00, 0, 8'h00, 0, 0);
        check("rx_turn_oe", bus.ulpi_data_oe, 0);
        for (int i = 0; i < 5; i++) begin
            tick(1, 1, rx_bytes[i], 0, 8'h00, 0, 0);
            check("rx_in_act", in_act, 1);
            if (i == 0) check("rx_no_latch", in_latch, 0);
            else begin
                check("rx_latch", in_latch, 1);
                check("rx_byte", in_byte, rx_bytes[i-1]);
            end
        end
        tick(0, 0, 8'h00, 0, 8'h00, 0, 0);
        check("rx_last_latch", in_latch, 1);
        check("rx_last_byte", in_byte, rx_bytes[4]);
        check("rx_act_hold", in_act, 1);
        idle(1);
        check("rx_end_latch", in_latch, 0);
        check("rx_end_act", in_act, 0);

        // RX CMD decode.
        tick(1, 0, 8'h00, 0, 8'h00, 0, 0);
        tick(1, 0, 8'h1D, 0, 8'h00, 0, 0);
        tick(1, 0, 8'h3D, 0, 8'h00, 0, 0);
        check("rxcmd_line", line_state, 2'b01);
        check("rxcmd_vbus", vbus_state, 2'b11);
        check("rxcmd_act", in_act, 1);
        check("rxcmd_no_err", rx_error, 0);
        tick(1, 0, 8'h2D, 0, 8'h00, 0, 0);
        check("rxcmd_err", rx_error, 1);
        check("rxcmd_err_act", in_act, 1);
        tick(1, 0, 8'h0D, 0, 8'h00, 0, 0);
        check("rxcmd_err_once", rx_error, 0);
        check("rxcmd_disc", host_disc, 1);
        tick(0, 0, 8'h00, 0, 8'h00, 0, 0);
        check("rxcmd_disc_clr", host_disc, 0);
        check("rxcmd_act_clr", in_act, 0);
        idle(2);
        check("tx_cts_ready", out_cts, 1);

        // Transmit: TX CMD 0x42, nxt on the fourth cycle, two data bytes, stop.
        tick(0, 0, 8'h00, 1, 8'h42, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 8'h00, 0, 8'h42, 0, 0);
            check("tx_cmd_oe", bus.ulpi_data_oe, 1);
            check("tx_cmd_dout", bus.ulpi_data_out, 8'h42);
            check("tx_cmd_nxt", out_nxt, 0);
        end
        tick(0, 1, 8'h00, 0, 8'h42, 0, 0);
        check("tx_cmd_acc_dout", bus.ulpi_data_out, 8'h42);
        check("tx_cmd_acc_nxt", out_nxt, 1);
        tick(0, 1, 8'h00, 0, 8'hA1, 0, 0);
        check("tx_d0_dout", bus.ulpi_data_out, 8'hA1);
        check("tx_d0_nxt", out_nxt, 1);
        tick(0, 1, 8'h00, 0, 8'hA2, 0, 0);
        check("tx_d1_dout", bus.ulpi_data_out, 8'hA2);
        check("tx_d1_oe", bus.ulpi_data_oe, 1);
        tick(0, 0, 8'h00, 0, 8'h00, 1, 0);
        check("tx_stp", bus.ulpi_stp, 1);
        check("tx_stp_dout", bus.ulpi_data_out, 8'h00);
        check("tx_stp_oe", bus.ulpi_data_oe, 1);
        idle(1);
        check("tx_idle_stp", bus.ulpi_stp, 0);
        check("tx_idle_oe", bus.ulpi_data_oe, 0);
        idle(1);
        check("tx_idle_cts", out_cts, 1);

        // Register write 0x04 <= 0x45, nxt delayed two cycles in each phase.
        tick(0, 0, 8'h00, 0, 8'h00, 0, 1);
        tick(0, 0, 8'h00, 0, 8'h00, 0, 1);
        check("rw_cmd_dout", bus.ulpi_data_out, 8'h84);
        check("rw_cmd_oe", bus.ulpi_data_oe, 1);
        tick(0, 0, 8'h00, 0, 8'h00, 0, 1);
        check("rw_cts_busy", out_cts, 0);
        tick(0, 1, 8'h00, 0, 8'h00, 0, 1);
        check("rw_cmd_hold", bus.ulpi_data_out, 8'h84);
        tick(0, 0, 8'h00, 0, 8'h00, 0, 1);
        check("rw_data_dout", bus.ulpi_data_out, 8'h45);
        tick(0, 0, 8'h00, 0, 8'h00, 0, 1);
        tick(0, 1, 8'h00, 0, 8'h00, 0, 1);
        check("rw_data_hold", bus.ulpi_data_out, 8'h45);
        tick(0, 0, 8'h00, 0, 8'h00, 0, 1);
        check("rw_stp", bus.ulpi_stp, 1);
        check("rw_stp_done", reg_done, 0);
        tick(0, 0, 8'h00, 0, 8'h00, 0, 1);
        check("rw_done", reg_done, 1);
        check("rw_err", reg_err, 0);
        check("rw_after_stp", bus.ulpi_stp, 0);
        check("rw_after_oe", bus.ulpi_data_oe, 0);
        idle(1);
        check("rw_done_pulse", reg_done, 0);
        idle(1);

        // Register write with no nxt: abort after 255 cycles.
        tick(0, 0, 8'h00, 0, 8'h00, 0, 1);
        tick(0, 0, 8'h00, 0, 8'h00, 0, 1);
        check("rwto_cmd_dout", bus.ulpi_data_out, 8'h84);
        wait_n = 0;
        for (int i = 1; i <= 300; i++) begin
            tick(0, 0, 8'h00, 0, 8'h00, 0, 1);
            if (reg_done) begin
                wait_n = i;
                break;
            end
        end
        check("rwto_cycles", wait_n, 255);
        check("rwto_err", reg_err, 1);
        check("rwto_oe", bus.ulpi_data_oe, 0);
        idle(2);

        // PHY takes the bus during TX CMD.
        tick(0, 0, 8'h00, 1, 8'h40, 0, 0);
        tick(0, 0, 8'h00, 0, 8'h40, 0, 0);
        check("ab_cmd_oe", bus.ulpi_data_oe, 1);
        tick(1, 1, 8'h00, 0, 8'h40, 0, 0);
        check("ab_oe_drop", bus.ulpi_data_oe, 0);
        check("ab_not_yet", tx_abort, 0);
        tick(1, 1, 8'h5A, 0, 8'h00, 0, 0);
        check("ab_pulse", tx_abort, 1);
        check("ab_in_act", in_act, 1);
        tick(1, 1, 8'h5B, 0, 8'h00, 0, 0);
        check("ab_pulse_end", tx_abort, 0);
        check("ab_rx0", in_byte, 8'h5A);
        check("ab_rx0_latch", in_latch, 1);
        tick(0, 0, 8'h00, 0, 8'h00, 0, 0);
        check("ab_rx1", in_byte, 8'h5B);
        idle(1);
        check("ab_act_clr", in_act, 0);
        idle(2);

        // Asynchronous reset in the middle of a transmit releases the bus at once.
        tick(0, 0, 8'h00, 1, 8'h55, 0, 0);
        tick(0, 0, 8'h00, 0, 8'h55, 0, 0);
        check("ar_oe_before", bus.ulpi_data_oe, 1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_oe", bus.ulpi_data_oe, 0);
        check("ar_stp", bus.ulpi_stp, 1);
        check("ar_dout", bus.ulpi_data_out, 0);
        repeat (2) @(posedge phy_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
